// File: rtl/morse_sequence_packer.sv
// -----------------------------------------------------------------------------
// morse_sequence_packer
//
// Packs a stream of Morse dot/dash symbols into fixed-width sequence words.
// Symbols collect in an assembly buffer, first symbol in the top two bits.
// A Space or EndSeq terminator pushes the word into a small show-ahead FIFO.
// An empty slot reads 2'b11, so an empty sequence is an all-ones word.
//
// Optional feature: define MORSE_SEQ_LEN_EN to add the Out_Len port. Each FIFO
// word then also carries its stored symbol count.
//
// Parameters
//   MAX_SYMBOLS  symbols held per sequence (1..16)
//   OUT_DEPTH    output FIFO depth in words (power of two, 2..16)
//
// Ports
//   Clk              clock, rising edge
//   Reset_n          asynchronous active-low reset
//   Clear            synchronous flush of the sequence being assembled
//   Signals[2:0]     000 dot, 001 dash, 010 Space, 011 EndSeq, 1xx illegal
//   Sig_Valid        Signals valid this cycle
//   Sig_Ready        input accepted this cycle (FIFO not full)
//   EncSeq           head-of-FIFO packed sequence (all ones when empty)
//   Space_EndSeqbar  head terminator: 1 = Space, 0 = EndSeq
//   Out_Ovf          head word lost symbols to overflow
//   Out_Valid        FIFO non-empty
//   Out_Ready        consumer takes the head word
//   Illegal          one-cycle pulse after a 1xx code is accepted
//   Out_Len          (MORSE_SEQ_LEN_EN only) head word symbol count, 0 if empty
// -----------------------------------------------------------------------------
module morse_sequence_packer #(
   parameter int MAX_SYMBOLS = 5,
   parameter int OUT_DEPTH   = 4
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         Clear,
   input  logic [2:0]                   Signals,
   input  logic                         Sig_Valid,
   output logic                         Sig_Ready,
   output logic [2*MAX_SYMBOLS-1:0]     EncSeq,
   output logic                         Space_EndSeqbar,
   output logic                         Out_Ovf,
   output logic                         Out_Valid,
   input  logic                         Out_Ready,
   output logic                         Illegal
`ifdef MORSE_SEQ_LEN_EN
   ,
   output logic [$clog2(MAX_SYMBOLS+1)-1:0] Out_Len
`endif
);

   localparam int W  = 2 * MAX_SYMBOLS;
   localparam int CW = $clog2(MAX_SYMBOLS + 1);
   localparam int PW = $clog2(OUT_DEPTH);
   localparam int EW = W + 2;                    // {sequence, terminator, ovf}
   localparam logic [PW:0]   PTR_ONE = (PW+1)'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_SYMBOLS);

   logic [W-1:0]  asm_q;
   logic [W-1:0]  asm_ins;
   logic [CW-1:0] cnt_q;
   logic          ovf_q;
   logic          illegal_q;
   logic [PW:0]   wr_ptr_q;
   logic [PW:0]   rd_ptr_q;
   logic [EW-1:0] mem [OUT_DEPTH];
   logic [EW-1:0] head;

   logic accept, is_sym, is_term, is_ill;
   logic fifo_empty, fifo_full, push, pop;

   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      // Same slot index but different wrap bit means the writer lapped the reader.
      fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      accept     = Sig_Valid && !fifo_full && !Clear;
      is_sym     = accept && (Signals[2:1] == 2'b00);
      is_term    = accept && (Signals[2:1] == 2'b01);
      is_ill     = accept && Signals[2];
      push       = is_term;
      pop        = !fifo_empty && Out_Ready;
   end

   // Slot k sits at bits [W-1-2k -: 2]; the current count selects the next free slot.
   always_comb begin
      asm_ins = asm_q;
      for (int k = 0; k < MAX_SYMBOLS; k++) begin
         if (cnt_q == CW'(k)) asm_ins[W-1-2*k -: 2] = Signals[1:0];
      end
   end

   // ---- Assembly stage: buffer, count and sticky overflow ----
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         asm_q     <= '1;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= is_ill;
         if (Clear || is_term) begin
            asm_q <= '1;
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else if (is_sym) begin
            if (cnt_q == CNT_MAX) begin
               ovf_q <= 1'b1;
            end else begin
               asm_q <= asm_ins;
               cnt_q <= cnt_q + CNT_ONE;
            end
         end
      end
   end

   // ---- FIFO stage: pointers carry one wrap bit beyond the slot index ----
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage is data only; the pointers decide whether a slot is meaningful.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr_q[PW-1:0]] <= {asm_q, ~Signals[0], ovf_q};
   end

`ifdef MORSE_SEQ_LEN_EN
   logic [CW-1:0] len_mem [OUT_DEPTH];

   always_ff @(posedge Clk) begin
      if (push) len_mem[wr_ptr_q[PW-1:0]] <= cnt_q;
   end

   assign Out_Len = fifo_empty ? '0 : len_mem[rd_ptr_q[PW-1:0]];
`endif

   // ---- Output stage: show-ahead head word, forced to idle values when empty ----
   assign head            = mem[rd_ptr_q[PW-1:0]];
   assign Sig_Ready       = !fifo_full;
   assign Out_Valid       = !fifo_empty;
   assign EncSeq          = fifo_empty ? '1   : head[EW-1:2];
   assign Space_EndSeqbar = fifo_empty ? 1'b0 : head[1];
   assign Out_Ovf         = fifo_empty ? 1'b0 : head[0];
   assign Illegal         = illegal_q;

endmodule

// File: tb/tb_morse_sequence_packer.sv
module tb_morse_sequence_packer;

   localparam int MS = 5;
   localparam int D  = 2;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Clear = 1'b0;
   logic [2:0] Signals = 3'b000;
   logic       Sig_Valid = 1'b0;
   logic       Sig_Ready;
   logic [9:0] EncSeq;
   logic       Space_EndSeqbar;
   logic       Out_Ovf;
   logic       Out_Valid;
   logic       Out_Ready = 1'b0;
   logic       Illegal;
`ifdef MORSE_SEQ_LEN_EN
   logic [2:0] Out_Len;
`endif

   morse_sequence_packer #(.MAX_SYMBOLS(MS), .OUT_DEPTH(D)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .Signals(Signals),
      .Sig_Valid(Sig_Valid), .Sig_Ready(Sig_Ready), .EncSeq(EncSeq),
      .Space_EndSeqbar(Space_EndSeqbar), .Out_Ovf(Out_Ovf),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Illegal(Illegal)
`ifdef MORSE_SEQ_LEN_EN
      , .Out_Len(Out_Len)
`endif
   );

   always #5 Clk = ~Clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_len(input string nm, input int exp);
`ifdef MORSE_SEQ_LEN_EN
      chk(nm, 32'(Out_Len), exp);
`endif
   endtask

   // Entered and left just after a falling edge; Signals is live for one rising edge.
   task automatic send(input logic [2:0] code);
      Signals = code;
      Sig_Valid = 1'b1;
      @(negedge Clk);
      Sig_Valid = 1'b0;
   endtask

   task automatic pop_one();
      Out_Ready = 1'b1;
      @(negedge Clk);
      Out_Ready = 1'b0;
   endtask

   // ---------------- table of whole sequences ----------------
   typedef struct packed {
      logic [3:0]  n;
      logic [23:0] syms;     // code i at [3*i +: 3]
      logic [9:0]  enc;
      logic        sp;
      logic        ovf;
      logic [2:0]  len;
   } vec_t;

   vec_t tbl [6];

   // ---------------- reference model for random traffic ----------------
   typedef struct packed {
      logic [9:0] enc;
      logic       sp;
      logic       ovf;
      logic [2:0] len;
   } word_t;

   word_t mq[$];
   int    syms[$];

   // Keep the first MS symbols, pad with empty (3) codes, read as a base-4 number.
   function automatic word_t make_word(input int s[$], input logic sp);
      word_t w;
      int n, val;
      n = (s.size() < MS) ? s.size() : MS;
      val = 0;
      for (int i = 0; i < n; i++)  val = val * 4 + s[i];
      for (int i = n; i < MS; i++) val = val * 4 + 3;
      w.enc = val[9:0];
      w.sp  = sp;
      w.ovf = (s.size() > MS);
      w.len = 3'(n);
      return w;
   endfunction

   initial begin
      logic       sv, clr, ordy, acc, ill_exp;
      logic [2:0] code;
      int         r;

      tbl[0] = '{4'd4, 24'({3'b011, 3'b001, 3'b001, 3'b000}), 10'b0001011111, 1'b0, 1'b0, 3'd3};
      tbl[1] = '{4'd7, 24'({3'b010, 18'b0}),                  10'b0000000000, 1'b1, 1'b1, 3'd5};
      tbl[2] = '{4'd1, 24'(3'b011),                            10'b1111111111, 1'b0, 1'b0, 3'd0};
      tbl[3] = '{4'd6, 24'({3'b010, {5{3'b001}}}),             10'b0101010101, 1'b1, 1'b0, 3'd5};
      tbl[4] = '{4'd4, 24'({3'b011, 3'b001, 3'b101, 3'b000}), 10'b0001111111, 1'b0, 1'b0, 3'd2};
      tbl[5] = '{4'd3, 24'({3'b010, 3'b000, 3'b001}),         10'b0100111111, 1'b1, 1'b0, 3'd2};

      // ---- reset state ----
      @(posedge Clk);
      @(negedge Clk);
      chk("rst_ready", Sig_Ready, 1);
      chk("rst_valid", Out_Valid, 0);
      chk("rst_enc", EncSeq, 10'h3FF);
      chk("rst_sp", Space_EndSeqbar, 0);
      chk("rst_ovf", Out_Ovf, 0);
      chk("rst_ill", Illegal, 0);
      chk_len("rst_len", 0);
      Reset_n = 1'b1;
      @(negedge Clk);

      // ---- table-driven sequences ----
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < int'(tbl[i].n); j++) send(tbl[i].syms[3*j +: 3]);
         chk("tbl_valid", Out_Valid, 1);
         chk("tbl_enc", EncSeq, tbl[i].enc);
         chk("tbl_sp", Space_EndSeqbar, tbl[i].sp);
         chk("tbl_ovf", Out_Ovf, tbl[i].ovf);
         chk_len("tbl_len", int'(tbl[i].len));
         pop_one();
         chk("tbl_valid_after_pop", Out_Valid, 0);
      end

      // ---- full FIFO back-pressure ----
      send(3'b010);
      chk("full_ready1", Sig_Ready, 1);
      send(3'b010);
      chk("full_ready0", Sig_Ready, 0);
      send(3'b010);                        // ignored while full
      send(3'b000);                        // ignored, must not enter the buffer
      chk("full_still_ready0", Sig_Ready, 0);
      Out_Ready = 1'b1;
      chk("full_head1", EncSeq, 10'h3FF);
      chk("full_sp1", Space_EndSeqbar, 1);
      @(negedge Clk);
      chk("full_valid2", Out_Valid, 1);
      chk("full_head2", EncSeq, 10'h3FF);
      chk("full_ready_again", Sig_Ready, 1);
      @(negedge Clk);
      chk("full_drained", Out_Valid, 0);
      Out_Ready = 1'b0;
      send(3'b011);                        // buffer must still be empty
      chk("full_buf_kept", EncSeq, 10'h3FF);
      pop_one();

      // ---- push and pop on the same edge ----
      send(3'b010);
      Out_Ready = 1'b1;
      send(3'b011);
      Out_Ready = 1'b0;
      chk("pp_valid", Out_Valid, 1);
      chk("pp_sp", Space_EndSeqbar, 0);
      pop_one();
      chk("pp_empty", Out_Valid, 0);

      // ---- Clear beats a simultaneous symbol ----
      send(3'b000);
      Signals = 3'b001; Sig_Valid = 1'b1; Clear = 1'b1;
      @(negedge Clk);
      Sig_Valid = 1'b0; Clear = 1'b0;
      send(3'b011);
      chk("clr_enc", EncSeq, 10'h3FF);
      chk_len("clr_len", 0);
      pop_one();

      // ---- illegal code ----
      send(3'b101);
      chk("ill_pulse", Illegal, 1);
      @(negedge Clk);
      chk("ill_drop", Illegal, 0);
      send(3'b011);
      chk("ill_word", EncSeq, 10'h3FF);
      pop_one();

      // ---- asynchronous reset mid-clock ----
      send(3'b010);
      send(3'b000);
      send(3'b000);
      @(posedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      chk("arst_valid", Out_Valid, 0);
      chk("arst_ready", Sig_Ready, 1);
      #1 Reset_n = 1'b1;
      @(negedge Clk);
      send(3'b011);
      chk("arst_enc", EncSeq, 10'h3FF);
      chk_len("arst_len", 0);
      pop_one();
      chk("arst_empty", Out_Valid, 0);

      // ---- randomized traffic against the model ----
      ill_exp = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         chk("rnd_ready", Sig_Ready, 32'(mq.size() < D));
         chk("rnd_valid", Out_Valid, 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("rnd_enc", EncSeq, mq[0].enc);
            chk("rnd_sp", Space_EndSeqbar, mq[0].sp);
            chk("rnd_ovf", Out_Ovf, mq[0].ovf);
            chk_len("rnd_len", int'(mq[0].len));
         end else begin
            chk("rnd_idle_enc", EncSeq, 10'h3FF);
            chk_len("rnd_idle_len", 0);
         end
         chk("rnd_ill", Illegal, ill_exp);

         sv   = ($urandom_range(0, 9) < 7);
         clr  = ($urandom_range(0, 24) == 0);
         ordy = ($urandom_range(0, 2) != 0);
         r    = $urandom_range(0, 11);
         if (r < 5)       code = 3'b000;
         else if (r < 9)  code = 3'b001;
         else if (r < 10) code = 3'b010;
         else if (r < 11) code = 3'b011;
         else             code = {1'b1, 2'($urandom_range(0, 3))};
         Signals = code; Sig_Valid = sv; Clear = clr; Out_Ready = ordy;

         acc = sv && (mq.size() < D) && !clr;
         if (clr) syms.delete();
         if (ordy && mq.size() != 0) void'(mq.pop_front());
         if (acc) begin
            if (code[2:1] == 2'b00) syms.push_back(int'(code[1:0]));
            else if (code[2:1] == 2'b01) begin
               mq.push_back(make_word(syms, ~code[0]));
               syms.delete();
            end
         end
         ill_exp = acc && code[2];
         @(negedge Clk);
      end
      Sig_Valid = 1'b0; Clear = 1'b0; Out_Ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
